rom_load_ctrl: RTL and testbench
================================

// Module: rom_load_ctrl
// PURPOSE
//  Sequences the HPS ROM download into the game core's ROM regions and owns core reset.
//  - Decodes download bytes into four regions: main CPU ROM, sound ROM, GFX ROM and PROM.
//  - Holds the core in reset while loading and for a fixed hold time afterwards.
//  - Keeps the core in reset after a short or bad download, and reports status and a checksum.
//  Sits between hps_io ioctl_* and the ROM write ports of scramble_top.
// PARAMETERS
//  CPU_BASE     16'h0000  main CPU ROM start; region size CPU_SIZE=16'h5000
//  SND_BASE     16'h5000  sound CPU ROM start; SND_SIZE=16'h1000
//  GFX_BASE     16'h6000  tile/sprite ROM start; GFX_SIZE=16'h1000
//  PROM_BASE    16'h7000  colour PROM start; PROM_SIZE=16'h0020
//  EXPECTED_LEN 17'h07020 minimum accepted byte count for a good load
//  HOLD_CYCLES  16        core_reset hold after load done (clk cycles)
// PORTS
//  clk          in   1   system clock
//  RESET        in   1   async, active-high; applies the reset state below
//  dn_download  in   1   download-active level from hps_io
//  dn_wr        in   1   one-cycle byte strobe
//  dn_addr      in   16  byte address of dn_data
//  dn_data      in   8   download byte
//  ext_reset    in   1   menu/button reset request, level
//  rom_wr_addr  out  16  region-relative address (dn_addr - region base)
//  rom_wr_data  out  8   registered dn_data
//  cpu_rom_we   out  1   write strobe, CPU ROM region
//  snd_rom_we   out  1   write strobe, sound ROM region
//  gfx_rom_we   out  1   write strobe, GFX ROM region
//  prom_we      out  1   write strobe, PROM region
//  core_reset   out  1   reset to scramble_top, registered
//  load_ok      out  1   last load was good (level)
//  load_err     out  1   last load was short (level)
//  checksum     out  8   mod-256 sum of accepted bytes of the last load
// BEHAVIOUR
//  Reset: state=IDLE; all *_we=0; addr/data=0; core_reset=1; load_ok=0; load_err=0; checksum=0; counters=0.
//  FSM, evaluated on the registered dn_download level dl_q and the previous level dl_qq:
//   IDLE -> LOAD on dl_q rise. core_reset=1.
//   LOAD: on entry clear byte_cnt, checksum, load_ok and load_err.
//     On dl_q fall: byte_cnt>=EXPECTED_LEN -> HOLD with load_ok=1; otherwise -> ERR with load_err=1.
//   HOLD: count HOLD_CYCLES, then -> RUN. ext_reset=1 restarts the count. core_reset=1.
//   RUN: core_reset=ext_reset. dl_q rise -> LOAD.
//   ERR: core_reset=1 until dl_q rise -> LOAD. A failed core never runs.
//  Write path (only in LOAD, including the cycle dl_q falls):
//   - A dn_wr in a region asserts exactly one *_we for one cycle, one clk after dn_wr.
//   - rom_wr_addr and rom_wr_data are valid with that strobe.
//   - Accepted: byte_cnt+=1 (17 bit, saturating); checksum+=dn_data (mod 256).
//   - Address in no region (>= PROM_BASE+PROM_SIZE, or a gap between regions): no strobe, not counted.
//   - A region matches on base<=addr<base+size; regions never overlap.
//   - dn_wr outside LOAD is ignored.
//  Simultaneous events:
//   - dn_wr on the dl_q falling cycle: counted before the length check.
//   - dl_q rise during HOLD: -> LOAD.
//   - RESET during LOAD: aborts to IDLE; the next download starts a fresh load.
//  Back-to-back dn_wr every cycle: full throughput, no drop; no stall output needed.
// STRUCTURE
//  Package rom_load_pkg:
//   - state enum {IDLE, LOAD, HOLD, RUN, ERR};
//   - region id enum {R_NONE, R_CPU, R_SND, R_GFX, R_PROM};
//   - default base/size localparams.
//  Sub-module rom_region_decode: combinational addr -> {region id, relative addr}.
//  Top holds the FSM, hold counter, byte counter, checksum and output registers.
// TESTING
//  1 Full load: writes 0x0000..0x701F, data=addr[7:0], then dl falls
//    -> 0x5000 cpu_rom_we pulses, checksum matches the model;
//    -> load_ok=1; core_reset low exactly 16 clk after HOLD entry.
//  2 Short load: last write at 0x3FFF -> load_err=1, core_reset stays 1, no RUN.
//  3 Region edges: write 0x4FFF -> cpu_we, addr 0x4FFF; write 0x5000 -> snd_we, addr 0x0000;
//    write 0x701F -> prom_we, addr 0x1F; write 0x7020 -> no strobe, byte_cnt unchanged.
//  4 Edge timing: dn_wr on the dl falling cycle at 0x701F, with byte_cnt at 0x701F before it
//    -> counted, load_ok=1.
//  5 Reset interplay: ext_reset mid-HOLD -> HOLD count restarts;
//    ext_reset in RUN -> core_reset follows it 1 clk later.
//  6 Abort: RESET asserted mid-LOAD -> IDLE, core_reset=1, flags 0; a new full load passes.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and default memory map for the ROM download controller.
// The region test compares in 17 bits so that base + size cannot wrap at the top of the map.
package rom_load_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_e;
   typedef enum logic [2:0] {R_NONE, R_CPU, R_SND, R_GFX, R_PROM} region_e;

   localparam logic [15:0] CPU_BASE_DEF     = 16'h0000;
   localparam logic [15:0] CPU_SIZE_DEF     = 16'h5000;
   localparam logic [15:0] SND_BASE_DEF     = 16'h5000;
   localparam logic [15:0] SND_SIZE_DEF     = 16'h1000;
   localparam logic [15:0] GFX_BASE_DEF     = 16'h6000;
   localparam logic [15:0] GFX_SIZE_DEF     = 16'h1000;
   localparam logic [15:0] PROM_BASE_DEF    = 16'h7000;
   localparam logic [15:0] PROM_SIZE_DEF    = 16'h0020;
   localparam logic [16:0] EXPECTED_LEN_DEF = 17'h07020;
   localparam int unsigned HOLD_CYCLES_DEF  = 16;

   function automatic logic in_region(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] size);
      return ({1'b0, addr} >= {1'b0, base}) &&
             ({1'b0, addr} <  ({1'b0, base} + {1'b0, size}));
   endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational download-address decoder: selects the ROM region and the
// address relative to that region's base. Unmapped addresses give R_NONE.
module rom_region_decode
   import rom_load_pkg::*;
#(
   parameter logic [15:0] CPU_BASE  = CPU_BASE_DEF,
   parameter logic [15:0] CPU_SIZE  = CPU_SIZE_DEF,
   parameter logic [15:0] SND_BASE  = SND_BASE_DEF,
   parameter logic [15:0] SND_SIZE  = SND_SIZE_DEF,
   parameter logic [15:0] GFX_BASE  = GFX_BASE_DEF,
   parameter logic [15:0] GFX_SIZE  = GFX_SIZE_DEF,
   parameter logic [15:0] PROM_BASE = PROM_BASE_DEF,
   parameter logic [15:0] PROM_SIZE = PROM_SIZE_DEF
)
(
   input  logic [15:0] addr_i,
   output region_e     region_o,
   output logic [15:0] rel_addr_o
);

   always_comb begin
      region_o   = R_NONE;
      rel_addr_o = '0;
      if (in_region(addr_i, CPU_BASE, CPU_SIZE)) begin
         region_o   = R_CPU;
         rel_addr_o = addr_i - CPU_BASE;
      end else if (in_region(addr_i, SND_BASE, SND_SIZE)) begin
         region_o   = R_SND;
         rel_addr_o = addr_i - SND_BASE;
      end else if (in_region(addr_i, GFX_BASE, GFX_SIZE)) begin
         region_o   = R_GFX;
         rel_addr_o = addr_i - GFX_BASE;
      end else if (in_region(addr_i, PROM_BASE, PROM_SIZE)) begin
         region_o   = R_PROM;
         rel_addr_o = addr_i - PROM_BASE;
      end
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ROM download into the core ROM regions, owns core reset,
// and reports load status plus a mod-256 checksum of the accepted bytes.
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter logic [15:0] CPU_BASE     = CPU_BASE_DEF,
   parameter logic [15:0] CPU_SIZE     = CPU_SIZE_DEF,
   parameter logic [15:0] SND_BASE     = SND_BASE_DEF,
   parameter logic [15:0] SND_SIZE     = SND_SIZE_DEF,
   parameter logic [15:0] GFX_BASE     = GFX_BASE_DEF,
   parameter logic [15:0] GFX_SIZE     = GFX_SIZE_DEF,
   parameter logic [15:0] PROM_BASE    = PROM_BASE_DEF,
   parameter logic [15:0] PROM_SIZE    = PROM_SIZE_DEF,
   parameter logic [16:0] EXPECTED_LEN = EXPECTED_LEN_DEF,
   parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        RESET,
   input  logic        dn_download,
   input  logic        dn_wr,
   input  logic [15:0] dn_addr,
   input  logic [7:0]  dn_data,
   input  logic        ext_reset,
   output logic [15:0] rom_wr_addr,
   output logic [7:0]  rom_wr_data,
   output logic        cpu_rom_we,
   output logic        snd_rom_we,
   output logic        gfx_rom_we,
   output logic        prom_we,
   output logic        core_reset,
   output logic        load_ok,
   output logic        load_err,
   output logic [7:0]  checksum
);

   localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

   state_e          state_q, state_d;
   logic            dl_q, dl_qq;
   logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [16:0]     byte_cnt_q, byte_cnt_d;
   logic [7:0]      checksum_q, checksum_d;
   logic            ok_q, ok_d, err_q, err_d;
   logic [15:0]     addr_q, addr_d;
   logic [7:0]      data_q, data_d;
   logic [3:0]      we_q, we_d;
   logic            core_reset_q, core_reset_d;

   region_e         region;
   logic [15:0]     rel_addr;
   logic            dl_rise, dl_fall, accept;

   rom_region_decode #(
      .CPU_BASE  (CPU_BASE),
      .CPU_SIZE  (CPU_SIZE),
      .SND_BASE  (SND_BASE),
      .SND_SIZE  (SND_SIZE),
      .GFX_BASE  (GFX_BASE),
      .GFX_SIZE  (GFX_SIZE),
      .PROM_BASE (PROM_BASE),
      .PROM_SIZE (PROM_SIZE)
   ) u_decode (
      .addr_i     (dn_addr),
      .region_o   (region),
      .rel_addr_o (rel_addr)
   );

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q      <= IDLE;
         dl_q         <= 1'b0;
         dl_qq        <= 1'b0;
         hold_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         checksum_q   <= '0;
         ok_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= '0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         dl_q         <= dn_download;
         dl_qq        <= dl_q;
         hold_cnt_q   <= hold_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         checksum_q   <= checksum_d;
         ok_q         <= ok_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         core_reset_q <= core_reset_d;
      end
   end

   always_comb begin
      dl_rise      = dl_q & ~dl_qq;
      dl_fall      = ~dl_q & dl_qq;
      accept       = (state_q == LOAD) && dn_wr && (region != R_NONE);

      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      checksum_d   = checksum_q;
      ok_d         = ok_q;
      err_d        = err_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = '0;
      core_reset_d = 1'b1;

      case (state_q)
         IDLE: if (dl_rise) state_d = LOAD;
         LOAD: begin
            if (accept) begin
               byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 17'd1;
               checksum_d = checksum_q + dn_data;
               addr_d     = rel_addr;
               data_d     = dn_data;
               case (region)
                  R_CPU:   we_d[0] = 1'b1;
                  R_SND:   we_d[1] = 1'b1;
                  R_GFX:   we_d[2] = 1'b1;
                  R_PROM:  we_d[3] = 1'b1;
                  default: we_d    = '0;
               endcase
            end
            // Length check sees byte_cnt_d so a write on the falling cycle counts.
            if (dl_fall) begin
               if (byte_cnt_d >= EXPECTED_LEN) begin
                  state_d    = HOLD;
                  ok_d       = 1'b1;
                  hold_cnt_d = '0;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         HOLD: begin
            if (dl_rise) begin
               state_d = LOAD;
            end else if (ext_reset) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HC_W'(HOLD_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         RUN:     if (dl_rise) state_d = LOAD;
         ERR:     if (dl_rise) state_d = LOAD;
         default: state_d = IDLE;
      endcase

      if ((state_d == LOAD) && (state_q != LOAD)) begin
         byte_cnt_d = '0;
         checksum_d = '0;
         ok_d       = 1'b0;
         err_d      = 1'b0;
      end

      if (state_d == RUN) core_reset_d = ext_reset;
   end

   assign rom_wr_addr = addr_q;
   assign rom_wr_data = data_q;
   assign cpu_rom_we  = we_q[0];
   assign snd_rom_we  = we_q[1];
   assign gfx_rom_we  = we_q[2];
   assign prom_we     = we_q[3];
   assign core_reset  = core_reset_q;
   assign load_ok     = ok_q;
   assign load_err    = err_q;
   assign checksum    = checksum_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: stimulus queues expected ROM writes from
// a memory-map model, a negedge monitor pops and compares every strobe.
module tb_rom_load_ctrl;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        dn_download = 1'b0;
   logic        dn_wr = 1'b0;
   logic [15:0] dn_addr = '0;
   logic [7:0]  dn_data = '0;
   logic        ext_reset = 1'b0;
   logic [15:0] rom_wr_addr;
   logic [7:0]  rom_wr_data;
   logic        cpu_rom_we, snd_rom_we, gfx_rom_we, prom_we;
   logic        core_reset, load_ok, load_err;
   logic [7:0]  checksum;

   always #5 clk = ~clk;

   rom_load_ctrl dut (
      .clk         (clk),
      .RESET       (RESET),
      .dn_download (dn_download),
      .dn_wr       (dn_wr),
      .dn_addr     (dn_addr),
      .dn_data     (dn_data),
      .ext_reset   (ext_reset),
      .rom_wr_addr (rom_wr_addr),
      .rom_wr_data (rom_wr_data),
      .cpu_rom_we  (cpu_rom_we),
      .snd_rom_we  (snd_rom_we),
      .gfx_rom_we  (gfx_rom_we),
      .prom_we     (prom_we),
      .core_reset  (core_reset),
      .load_ok     (load_ok),
      .load_err    (load_err),
      .checksum    (checksum)
   );

   typedef struct {
      logic [3:0]  we;
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t        exp_q[$];
   int         errors = 0;
   int         checks = 0;
   bit         in_load = 1'b0;
   int         m_cnt = 0;
   logic [7:0] m_sum = '0;
   int         cpu_seen = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Memory map model: {prom,gfx,snd,cpu} strobe and region base.
   function automatic logic [3:0] model_we(input int a);
      if (a < 'h5000) return 4'b0001;
      if (a < 'h6000) return 4'b0010;
      if (a < 'h7000) return 4'b0100;
      if (a < 'h7020) return 4'b1000;
      return 4'b0000;
   endfunction

   function automatic int model_base(input int a);
      if (a < 'h5000) return 'h0000;
      if (a < 'h6000) return 'h5000;
      if (a < 'h7000) return 'h6000;
      return 'h7000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      wr_t e;
      dn_wr   = 1'b1;
      dn_addr = a[15:0];
      dn_data = d;
      if (in_load && model_we(a) != 4'b0000) begin
         e.we   = model_we(a);
         e.addr = 16'(a - model_base(a));
         e.data = d;
         exp_q.push_back(e);
         if (m_cnt < 'h1FFFF) m_cnt++;
         m_sum += d;
      end
      tick();
      dn_wr = 1'b0;
   endtask

   task automatic start_load();
      dn_download = 1'b1;
      tick();
      tick();
      in_load = 1'b1;
      m_cnt   = 0;
      m_sum   = '0;
      chk("load_entry_ok", load_ok, 0);
      chk("load_entry_err", load_err, 0);
      chk("load_entry_checksum", checksum, 0);
   endtask

   task automatic end_load();
      dn_download = 1'b0;
      tick();
      tick();
      in_load = 1'b0;
   endtask

   task automatic check_result(input string tag);
      chk({tag, "_load_ok"}, load_ok, (m_cnt >= 'h7020) ? 1 : 0);
      chk({tag, "_load_err"}, load_err, (m_cnt >= 'h7020) ? 0 : 1);
      chk({tag, "_checksum"}, checksum, m_sum);
   endtask

   task automatic count_to_run(input string name);
      int n = 0;
      while (core_reset === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk(name, n, 16);
   endtask

   task automatic check_held(input string name, input int cycles);
      int low = 0;
      repeat (cycles) begin
         tick();
         if (core_reset !== 1'b1) low++;
      end
      chk(name, low, 0);
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   initial begin
      wr_t        e;
      logic [3:0] we;
      forever begin
         @(negedge clk);
         if (RESET) continue;
         we = {prom_we, gfx_rom_we, snd_rom_we, cpu_rom_we};
         if (cpu_rom_we) cpu_seen++;
         if (we != 4'b0000) begin
            if (exp_q.size() == 0) begin
               chk("spurious_we", {28'd0, we}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rom_write", {4'd0, we, rom_wr_addr, rom_wr_data},
                   {4'd0, e.we, e.addr, e.data});
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a;
      int k;
      int cpu_before;

      // Reset state
      tick();
      tick();
      chk("rst_core_reset", core_reset, 1);
      chk("rst_load_ok", load_ok, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_addr_data", {rom_wr_addr, rom_wr_data}, 0);
      chk("rst_we", {prom_we, gfx_rom_we, snd_rom_we, cpu_rom_we}, 0);
      RESET = 1'b0;
      repeat (3) tick();
      wr('h0100, 8'h5A);
      check_held("idle_core_reset", 5);

      // Full load with data = addr[7:0]
      cpu_before = cpu_seen;
      start_load();
      for (int i = 0; i < 'h7020; i++) begin
         wr(i, i[7:0]);
         if ($urandom_range(0, 15) == 0) tick();
      end
      end_load();
      check_result("full");
      count_to_run("hold_release_cycles");
      chk("full_drain", exp_q.size(), 0);
      chk("cpu_strobes", cpu_seen - cpu_before, 'h5000);

      // ext_reset while running, and writes ignored outside LOAD
      repeat (4) begin
         repeat ($urandom_range(1, 5)) tick();
         ext_reset = 1'b1;
         chk("run_ext_before", core_reset, 0);
         tick();
         chk("run_ext_follow", core_reset, 1);
         repeat ($urandom_range(0, 3)) tick();
         ext_reset = 1'b0;
         tick();
         chk("run_ext_release", core_reset, 0);
      end
      wr('h0000, 8'h11);
      wr('h7000, 8'h22);
      tick();

      // Short load ending at 0x3FFF
      start_load();
      for (int i = 'h3F00; i <= 'h3FFF; i++) wr(i, 8'($urandom));
      end_load();
      check_result("short");
      check_held("short_core_reset", 40);
      wr('h0010, 8'h33);
      tick();
      chk("short_drain", exp_q.size(), 0);

      // Region edges and unmapped addresses
      start_load();
      wr('h4FFF, 8'hA1);
      wr('h5000, 8'hA2);
      wr('h5FFF, 8'hA3);
      wr('h6000, 8'hA4);
      wr('h6FFF, 8'hA5);
      wr('h7000, 8'hA6);
      wr('h701F, 8'hA7);
      wr('h7020, 8'hA8);
      wr('h8000, 8'hA9);
      wr('hFFFF, 8'hAA);
      end_load();
      check_result("edges");
      tick();
      chk("edges_drain", exp_q.size(), 0);

      // Randomized short load over the whole address space
      start_load();
      repeat (400) begin
         case ($urandom_range(0, 3))
            0:       a = int'($urandom_range(0, 'hFFFF));
            1:       a = 'h7000 + int'($urandom_range(0, 'h3F));
            2:       a = 'h4FF0 + int'($urandom_range(0, 'h20));
            default: a = int'($urandom_range(0, 'h701F));
         endcase
         wr(a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) tick();
      end
      end_load();
      check_result("random");
      check_held("random_core_reset", 20);
      chk("random_drain", exp_q.size(), 0);

      // Abort mid-load with RESET, then a fresh full load
      start_load();
      repeat (500) wr(int'($urandom_range(0, 'h701F)), 8'($urandom));
      tick();
      chk("abort_drain", exp_q.size(), 0);
      in_load     = 1'b0;
      RESET       = 1'b1;
      dn_download = 1'b0;
      #1;
      chk("abort_core_reset", core_reset, 1);
      chk("abort_flags", {load_ok, load_err}, 0);
      chk("abort_checksum", checksum, 0);
      tick();
      tick();
      RESET = 1'b0;
      tick();
      wr('h0200, 8'h44);
      check_held("abort_idle_core_reset", 5);

      start_load();
      for (int i = 0; i < 'h701F; i++) begin
         wr(i, 8'($urandom));
         if ($urandom_range(0, 31) == 0) tick();
      end
      // Final byte lands on the cycle the registered download level falls.
      dn_download = 1'b0;
      tick();
      wr('h701F, 8'($urandom));
      in_load = 1'b0;
      check_result("fall_edge");

      // ext_reset in mid-HOLD restarts the hold count
      repeat (5) tick();
      chk("hold_mid_core_reset", core_reset, 1);
      k = int'($urandom_range(1, 4));
      ext_reset = 1'b1;
      repeat (k) tick();
      ext_reset = 1'b0;
      count_to_run("hold_restart_cycles");
      chk("final_drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
